// File: rtl/booth_pp_gen_pkg.sv
// Shared constants, Booth digit type and radix-4 encoder for the partial-product generator.
package booth_pkg;

   localparam int N   = 11;
   localparam int NPP = (N + 2) / 2;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   typedef logic [N+1:0] pp_row_t;

   // Triplet is {b[2i+1], b[2i], b[2i-1]}; a zero digit never carries neg.
   function automatic booth_digit_t booth_enc(input logic [2:0] t);
      booth_digit_t d;
      d = '0;
      case (t)
         3'b001, 3'b010: d.one = 1'b1;
         3'b011:         d.two = 1'b1;
         3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
         3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
         default:        d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_pp_gen_if.sv
// Operand input channel and partial-product output channel of the Booth generator.
interface booth_pp_gen_if;
   import booth_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [N-1:0]            a;
   logic [N-1:0]            b;
   logic                    out_valid;
   logic                    out_ready;
   pp_row_t [NPP-1:0]       ops;
   logic [NPP-1:0]          neg;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, ops, neg
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, ops, neg
   );

endinterface

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: selects 0/a/2a, one's-complements for negative digits.
module booth_pp_row
   import booth_pkg::*;
(
   input  booth_digit_t digit,
   input  logic [N-1:0] a,
   output pp_row_t      row,
   output logic         neg
);

   logic [N:0] mag;

   always_comb begin
      mag = '0;
      if (digit.one)
         mag = {1'b0, a};
      else if (digit.two)
         mag = {a, 1'b0};
   end

   // Top bit is the inverted sign; the tree adds the constant correction.
   assign row = {~digit.neg, digit.neg ? ~mag : mag};
   assign neg = digit.neg;

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage valid/ready pipeline: Booth-encode b, then build the NPP partial-product rows.
module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   booth_pp_gen_if.slave     bus,
   output logic [CNT_W-1:0]  txn_cnt
);

   logic                    vld_p1;
   logic                    vld_p2;
   logic [N-1:0]            a_p1;
   booth_digit_t [NPP-1:0]  dig_p1;
   pp_row_t [NPP-1:0]       ops_p2;
   logic [NPP-1:0]          neg_p2;

   booth_digit_t [NPP-1:0]  dig_c;
   pp_row_t [NPP-1:0]       row_c;
   logic [NPP-1:0]          neg_c;
   logic [2*NPP:0]          b_ext;
   logic                    s1_adv;
   logic                    s2_adv;
   logic                    accept;
   logic                    emit;

   assign s2_adv = !vld_p2 || bus.out_ready;
   assign s1_adv = !vld_p1 || s2_adv;
   assign accept = bus.in_valid && s1_adv;
   assign emit   = vld_p2 && bus.out_ready;

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = vld_p2;
   assign bus.ops       = ops_p2;
   assign bus.neg       = neg_p2;

   // b zero-extended to 2*NPP bits with the implicit b[-1]=0 below bit 0.
   assign b_ext = {{(2*NPP-N){1'b0}}, bus.b, 1'b0};

   always_comb begin
      dig_c = '0;
      for (int i = 0; i < NPP; i++)
         dig_c[i] = booth_enc(b_ext[2*i +: 3]);
   end

   // Stage 1 boundary: operand a and encoded digits.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1   <= bus.a;
         dig_p1 <= dig_c;
      end
   end

   for (genvar i = 0; i < NPP; i++) begin : g_row
      booth_pp_row u_row (
         .digit (dig_p1[i]),
         .a     (a_p1),
         .row   (row_c[i]),
         .neg   (neg_c[i])
      );
   end

   // Stage 2 boundary: partial-product rows, pipeline valids and emit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         ops_p2  <= '0;
         neg_p2  <= '0;
         txn_cnt <= '0;
      end else begin
         if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
         end else begin
            if (s1_adv)
               vld_p1 <= bus.in_valid;
            if (s2_adv)
               vld_p2 <= vld_p1;
            if (emit)
               txn_cnt <= txn_cnt + 1'b1;
         end
         if (s2_adv && vld_p1) begin
            ops_p2 <= row_c;
            neg_p2 <= neg_c;
         end
      end
   end

endmodule
